// File: rtl/f8_memory.sv
// Byte-addressed F8 memory: 24-bit instruction fetch, 16-bit data read, byte-enabled 16-bit write.
// Optional macro F8_MEM_ROM_PROTECT_EN drops byte writes below ROM_TOP.
module f8_memory #(
  parameter int unsigned MEM_SIZE = 65536,
  parameter logic [15:0] ROM_TOP  = 16'h4000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] iread_addr,
  output logic [23:0] iread_data,
  output logic        iread_valid,
  input  logic [15:0] dread_addr,
  output logic [15:0] dread_data,
  input  logic [15:0] dwrite_addr,
  input  logic [15:0] dwrite_data,
  input  logic [1:0]  dwrite_en
);

  localparam int unsigned AW = $clog2(MEM_SIZE);
  typedef logic [AW-1:0] addr_t;

  logic [7:0] mem [MEM_SIZE];

  addr_t w0, w1, i0, i1, i2, d0, d1;
  logic  we0, we1;
  logic [23:0] i_next;
  logic [15:0] d_next;

  // Address arithmetic is done at AW bits so every offset wraps modulo MEM_SIZE.
  assign w0 = dwrite_addr[AW-1:0];
  assign w1 = w0 + addr_t'(1);
  assign i0 = iread_addr[AW-1:0];
  assign i1 = i0 + addr_t'(1);
  assign i2 = i0 + addr_t'(2);
  assign d0 = dread_addr[AW-1:0];
  assign d1 = d0 + addr_t'(1);

`ifdef F8_MEM_ROM_PROTECT_EN
  assign we0 = dwrite_en[0] && (32'(w0) >= 32'(ROM_TOP));
  assign we1 = dwrite_en[1] && (32'(w1) >= 32'(ROM_TOP));
`else
  assign we0 = dwrite_en[0];
  assign we1 = dwrite_en[1];
`endif

  // Write-first per byte: a byte written on this edge is forwarded to the read.
  function automatic logic [7:0] rd_byte(input addr_t a);
    if (we1 && a == w1) return dwrite_data[15:8];
    if (we0 && a == w0) return dwrite_data[7:0];
    return mem[a];
  endfunction

  always_comb begin
    i_next = {rd_byte(i2), rd_byte(i1), rd_byte(i0)};
    d_next = {rd_byte(d1), rd_byte(d0)};
  end

  // The array shares this process only so writes are blocked while reset is low;
  // its contents are never cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iread_data  <= '0;
      dread_data  <= '0;
      iread_valid <= 1'b0;
    end else begin
      iread_data  <= i_next;
      dread_data  <= d_next;
      iread_valid <= 1'b1;
      if (we0) mem[w0] <= dwrite_data[7:0];
      if (we1) mem[w1] <= dwrite_data[15:8];
    end
  end

endmodule

// File: tb/tb_f8_memory.sv
// Scoreboard bench for f8_memory: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_f8_memory;

  localparam logic [15:0] ROM_TOP = 16'h4000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] iread_addr = '0;
  logic [23:0] iread_data;
  logic        iread_valid;
  logic [15:0] dread_addr = '0;
  logic [15:0] dread_data;
  logic [15:0] dwrite_addr = '0;
  logic [15:0] dwrite_data = '0;
  logic [1:0]  dwrite_en = '0;

  f8_memory #(.MEM_SIZE(65536), .ROM_TOP(ROM_TOP)) dut (
    .clk(clk), .reset(reset),
    .iread_addr(iread_addr), .iread_data(iread_data), .iread_valid(iread_valid),
    .dread_addr(dread_addr), .dread_data(dread_data),
    .dwrite_addr(dwrite_addr), .dwrite_data(dwrite_data), .dwrite_en(dwrite_en)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int unsigned due;
    logic [23:0] ie, im;
    logic [15:0] de, dm;
    string       tag;
  } exp_t;
  exp_t q[$];

  // Reference: flat byte array plus a known flag; 16-bit address math wraps at 64K.
  logic [7:0] mm [65536];
  bit         kn [65536];

  function automatic bit wr_ok(input logic [15:0] a);
`ifdef F8_MEM_ROM_PROTECT_EN
    return a >= ROM_TOP;
`else
    return a == a;
`endif
  endfunction

  task automatic step(input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wa,
                      input logic [15:0] wd, input logic [1:0] en, input string tag);
    exp_t e;
    logic [15:0] a;
    iread_addr = ia; dread_addr = da; dwrite_addr = wa; dwrite_data = wd; dwrite_en = en;
    // Apply the writes first: reads on the same edge see the new bytes.
    if (en[0] && wr_ok(wa)) begin mm[wa] = wd[7:0]; kn[wa] = 1'b1; end
    a = wa + 16'd1;
    if (en[1] && wr_ok(a)) begin mm[a] = wd[15:8]; kn[a] = 1'b1; end
    for (int k = 0; k < 3; k++) begin
      a = ia + 16'(k);
      e.ie[8*k +: 8] = mm[a];
      e.im[8*k +: 8] = kn[a] ? 8'hFF : 8'h00;
    end
    for (int k = 0; k < 2; k++) begin
      a = da + 16'(k);
      e.de[8*k +: 8] = mm[a];
      e.dm[8*k +: 8] = kn[a] ? 8'hFF : 8'h00;
    end
    e.tag = tag;
    e.due = cyc + 1;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due < cyc) begin
      tests++; fails++;
      $display("FAIL %s: expectation for cycle %0d never compared", q[0].tag, q[0].due);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      tests++;
      if (iread_valid !== 1'b1) begin
        fails++;
        $display("FAIL %s valid: got %b want 1", e.tag, iread_valid);
      end
      if (e.im != '0) begin
        tests++;
        if ((iread_data & e.im) !== (e.ie & e.im)) begin
          fails++;
          $display("FAIL %s iread: got %h want %h (mask %h)", e.tag, iread_data, e.ie, e.im);
        end
      end
      if (e.dm != '0) begin
        tests++;
        if ((dread_data & e.dm) !== (e.de & e.dm)) begin
          fails++;
          $display("FAIL %s dread: got %h want %h (mask %h)", e.tag, dread_data, e.de, e.dm);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (iread_data !== 24'h0 || dread_data !== 16'h0 || iread_valid !== 1'b0) begin
      fails++;
      $display("FAIL %s: got i=%h d=%h v=%b want i=000000 d=0000 v=0", tag,
               iread_data, dread_data, iread_valid);
    end
  endtask

  task automatic check_valid_high(input string tag);
    tests++;
    if (iread_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s: iread_valid got %b want 1", tag, iread_valid);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 10 && q.size() > 0; n++) @(posedge clk);
    @(negedge clk); #1;
    if (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations still pending, want 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [15:0] bases [4];
    logic [15:0] ia, da, wa;
    bases[0] = 16'h0100; bases[1] = 16'hFFFC; bases[2] = 16'h3FFC; bases[3] = 16'h0200;
    for (int i = 0; i < 65536; i++) begin mm[i] = 8'h00; kn[i] = 1'b0; end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_hold");
    reset = 1'b1;

    step(16'h0000, 16'h0000, 16'h0100, 16'hBEEF, 2'b11, "wr_beef");
    check_valid_high("valid_after_release");
    step(16'h00FF, 16'h0100, 16'h0000, 16'h0000, 2'b00, "rd_beef");
    step(16'h0000, 16'h0000, 16'h0100, 16'h1234, 2'b10, "wr_hi_only");
    step(16'h0100, 16'h0100, 16'h0000, 16'h0000, 2'b00, "rd_12ef");
    step(16'h0000, 16'h0000, 16'hFFFF, 16'hA55A, 2'b11, "wr_wrap");
    step(16'hFFFE, 16'hFFFF, 16'h0000, 16'h0000, 2'b00, "rd_wrap");
    step(16'h0000, 16'h0000, 16'h0202, 16'h0066, 2'b01, "wr_0202");
    step(16'h0000, 16'h0201, 16'h0200, 16'h7788, 2'b11, "overlap");
    step(16'h01FF, 16'h0200, 16'h0000, 16'h0000, 2'b00, "rd_after_overlap");
    step(16'h0000, 16'h0000, 16'h3FFF, 16'hFFFF, 2'b11, "wr_rom_edge");
    step(16'h3FFF, 16'h3FFF, 16'h0000, 16'h0000, 2'b00, "rd_rom_edge");

    for (int n = 0; n < 400; n++) begin
      ia = bases[$urandom_range(0, 3)] + 16'($urandom_range(0, 7));
      da = bases[$urandom_range(0, 3)] + 16'($urandom_range(0, 7));
      wa = bases[$urandom_range(0, 3)] + 16'($urandom_range(0, 7));
      step(ia, da, wa, 16'($urandom), 2'($urandom_range(0, 3)), "random");
    end
    drain();

    // Asynchronous reset mid-run; writes presented during reset must be ignored.
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    dwrite_addr = 16'h0100; dwrite_data = 16'hDEAD; dwrite_en = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_hold2");
    dwrite_en = 2'b00;
    reset = 1'b1;
    step(16'h00FF, 16'h0100, 16'h0000, 16'h0000, 2'b00, "rd_after_reset_write");
    check_valid_high("valid_after_release2");
    step(16'hFFFF, 16'h0201, 16'h0000, 16'h0000, 2'b00, "rd_after_reset_more");
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
